// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared constants for the 640x480 VGA display path.
//             - visible-area timing constants
//             - 12-bit {r,g,b} colour constants
//             - encoding of the block-flash state machine
//  Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

    // Visible area of the 640x480 mode
    localparam int c_H_ACTIVE = 640;
    localparam int c_V_ACTIVE = 480;

    // 12-bit colours, packed as {r[3:0], g[3:0], b[3:0]}
    localparam logic [11:0] c_BLACK = 12'h000;
    localparam logic [11:0] c_BLUE  = 12'h00F;
    localparam logic [11:0] c_GREEN = 12'h0F0;
    localparam logic [11:0] c_WHITE = 12'hFFF;

    // Flash state machine encoding
    localparam int c_ST_W = 2;
    typedef logic [c_ST_W-1:0] flash_state_t;
    localparam flash_state_t c_ST_IDLE = 2'd0;
    localparam flash_state_t c_ST_LIT  = 2'd1;
    localparam flash_state_t c_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/block_hit_detect.sv
`default_nettype none
// ============================================================================
//  Module   : block_hit_detect
//  Purpose  : Combinational pixel-to-block hit test for a row-major grid of
//             square blocks. Block i sits at col = i % COLS, row = i / COLS.
//             Ranges are half-open; the lowest block index wins on overlap.
//  Ports    : x, y     - current pixel column / row (unsigned, 10 bits)
//             hit      - pixel lies inside at least one block
//             hit_idx  - index of the lowest-numbered block containing it
//  Revision : 1.0  initial release
// ============================================================================
module block_hit_detect #(
    parameter int NUM_BLOCKS = 4,
    parameter int COLS       = 2,
    parameter int BLOCK_SIZE = 64,
    parameter int ORIGIN_X   = 266,
    parameter int ORIGIN_Y   = 169,
    parameter int PITCH_X    = 144,
    parameter int PITCH_Y    = 144
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       hit,
    output logic [2:0] hit_idx
);

    logic [NUM_BLOCKS-1:0] w_in_block;
    logic [10:0]           w_x_ext;
    logic [10:0]           w_y_ext;

    // One extra bit so bounds up to 2047 compare without wrap.
    assign w_x_ext = {1'b0, x};
    assign w_y_ext = {1'b0, y};

    for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_block
        // Bounds fold to constants at elaboration; no runtime multiply.
        localparam logic [10:0] c_X0 = 11'(ORIGIN_X + (gi % COLS) * PITCH_X);
        localparam logic [10:0] c_X1 = 11'(ORIGIN_X + (gi % COLS) * PITCH_X + BLOCK_SIZE);
        localparam logic [10:0] c_Y0 = 11'(ORIGIN_Y + (gi / COLS) * PITCH_Y);
        localparam logic [10:0] c_Y1 = 11'(ORIGIN_Y + (gi / COLS) * PITCH_Y + BLOCK_SIZE);

        assign w_in_block[gi] = (w_x_ext >= c_X0) && (w_x_ext < c_X1) &&
                                (w_y_ext >= c_Y0) && (w_y_ext < c_Y1);
    end

    // Scan from the top index down so the lowest matching index is left last.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
            if (w_in_block[i]) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_block_panel.sv
`default_nettype none
// ============================================================================
//  Module   : vga_block_panel
//  Purpose  : Game-board pixel renderer. Draws NUM_BLOCKS square blocks on a
//             background and can flash one block in LIT_COLOR for
//             FLASH_FRAMES video frames via a req/busy/done handshake.
//             Two-stage pixel pipeline (hit test, colour select) advancing
//             on pix_en only.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             pix_en              - one-clk pulse per pixel
//             video_on, x, y      - from the VGA timing generator
//             flash_req/flash_idx - flash request and block index
//             flash_busy          - flash in progress
//             flash_done          - one-clk pulse when a flash completes
//             vga_r/g/b           - 4-bit colour outputs
//  Revision : 1.0  initial release
// ============================================================================
module vga_block_panel
    import vga_pkg::*;
#(
    parameter int          NUM_BLOCKS   = 4,
    parameter int          COLS         = 2,
    parameter int          BLOCK_SIZE   = 64,
    parameter int          ORIGIN_X     = 266,
    parameter int          ORIGIN_Y     = 169,
    parameter int          PITCH_X      = 144,
    parameter int          PITCH_Y      = 144,
    parameter int          H_ACTIVE     = c_H_ACTIVE,
    parameter int          V_ACTIVE     = c_V_ACTIVE,
    parameter int          FLASH_FRAMES = 30,
    parameter logic [11:0] BG_COLOR     = c_BLUE,
    parameter logic [11:0] IDLE_COLOR   = c_GREEN,
    parameter logic [11:0] LIT_COLOR    = c_WHITE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       video_on,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       flash_req,
    input  logic [2:0] flash_idx,
    output logic       flash_busy,
    output logic       flash_done,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);

    localparam int                c_CNT_W     = $clog2(FLASH_FRAMES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(FLASH_FRAMES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [3:0]        c_IDX_LIMIT = 4'(NUM_BLOCKS);
    localparam logic [9:0]        c_X_LAST    = 10'(H_ACTIVE - 1);
    localparam logic [9:0]        c_Y_LAST    = 10'(V_ACTIVE - 1);

    // ------------------------------------------------------------------
    // Hit test (combinational)
    // ------------------------------------------------------------------
    logic       w_hit;
    logic [2:0] w_hit_idx;

    block_hit_detect #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .COLS       (COLS),
        .BLOCK_SIZE (BLOCK_SIZE),
        .ORIGIN_X   (ORIGIN_X),
        .ORIGIN_Y   (ORIGIN_Y),
        .PITCH_X    (PITCH_X),
        .PITCH_Y    (PITCH_Y)
    ) u_hit (
        .x       (x),
        .y       (y),
        .hit     (w_hit),
        .hit_idx (w_hit_idx)
    );

    // ------------------------------------------------------------------
    // Flash state machine
    // ------------------------------------------------------------------
    flash_state_t        r_state;
    flash_state_t        w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [2:0]          r_lit_idx;
    logic [2:0]          w_lit_idx_nxt;
    logic                w_frame_tick;
    logic                w_idx_valid;

    // Last visible pixel of the frame marks one elapsed frame.
    assign w_frame_tick = pix_en && (x == c_X_LAST) && (y == c_Y_LAST);
    assign w_idx_valid  = ({1'b0, flash_idx} < c_IDX_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_lit_idx <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_lit_idx <= w_lit_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_lit_idx_nxt = r_lit_idx;
        case (r_state)
            c_ST_IDLE: begin
                // A frame tick in the accepting clk does not count against
                // the new flash: the counter is simply loaded.
                if (flash_req && w_idx_valid) begin
                    w_state_nxt   = c_ST_LIT;
                    w_cnt_nxt     = c_CNT_INIT;
                    w_lit_idx_nxt = flash_idx;
                end
            end
            c_ST_LIT: begin
                if (w_frame_tick) begin
                    if (r_cnt == c_CNT_ONE) begin
                        w_state_nxt = c_ST_DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - c_CNT_ONE;
                    end
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign flash_busy = (r_state == c_ST_LIT);
    assign flash_done = (r_state == c_ST_DONE);

    // ------------------------------------------------------------------
    // Pixel pipeline: stage 1 = hit result, stage 2 = colour
    // ------------------------------------------------------------------
    logic        r_s1_hit;
    logic [2:0]  r_s1_idx;
    logic        r_s1_video;
    logic [11:0] r_rgb;
    logic [11:0] w_color;

    // Lit colour follows the live flash state, so a flash start/end shows
    // up on the next pix_en without waiting for a frame boundary.
    always_comb begin
        w_color = BG_COLOR;
        if (!r_s1_video) begin
            w_color = c_BLACK;
        end else if (r_s1_hit && (r_state == c_ST_LIT) && (r_s1_idx == r_lit_idx)) begin
            w_color = LIT_COLOR;
        end else if (r_s1_hit) begin
            w_color = IDLE_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_hit   <= 1'b0;
            r_s1_idx   <= 3'd0;
            r_s1_video <= 1'b0;
            r_rgb      <= 12'h000;
        end else if (pix_en) begin
            r_s1_hit   <= w_hit;
            r_s1_idx   <= w_hit_idx;
            r_s1_video <= video_on;
            r_rgb      <= w_color;
        end
    end

    assign vga_r = r_rgb[11:8];
    assign vga_g = r_rgb[7:4];
    assign vga_b = r_rgb[3:0];

endmodule
`default_nettype wire

// File: doc/vga_block_panel.md
Name: vga_block_panel

Overview:
- Parametrised pixel renderer for the game-board screen. Draws NUM_BLOCKS square blocks on a background in a row-major grid.
- Any one block can be "flashed" in a highlight colour for a fixed number of video frames, through a req/busy/done handshake.
- Sits between vga_controller (x, y, video_on) and the VGA pins. Replaces the fixed four-block colour logic.

Parameters:
- NUM_BLOCKS, 4, number of blocks (1..8).
- COLS, 2, blocks per grid row; block i is at col = i % COLS, row = i / COLS.
- BLOCK_SIZE, 64, block edge in pixels.
- ORIGIN_X, 266, left edge of block 0.
- ORIGIN_Y, 169, top edge of block 0.
- PITCH_X, 144, horizontal distance between block left edges.
- PITCH_Y, 144, vertical distance between block top edges.
- H_ACTIVE, 640, visible width.
- V_ACTIVE, 480, visible height.
- FLASH_FRAMES, 30, frames a flashed block stays lit (>= 1).
- BG_COLOR, 12'h00F, background {r,g,b}.
- IDLE_COLOR, 12'h0F0, unlit block colour.
- LIT_COLOR, 12'hFFF, flashed block colour.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pix_en  input  1  pixel-rate clock enable (one clk pulse per pixel)
- video_on  input  1  high during visible area
- x  input  10  current pixel column
- y  input  10  current pixel row
- flash_req  input  1  request to flash a block; sampled every clk
- flash_idx  input  3  block index for flash_req
- flash_busy  output  1  high while a flash is in progress
- flash_done  output  1  one-clk pulse when a flash completes
- vga_r  output  4  red
- vga_g  output  4  green
- vga_b  output  4  blue

Behaviour:
- Single clock, clk. reset is synchronous and active-high; all state updates on the posedge of clk.
- Reset values:
  - vga_r/g/b = 0.
  - flash_busy = 0, flash_done = 0.
  - FSM = IDLE, frame counter = 0, pipeline valid/video flags = 0.
- Pixel pipeline: advances only on clk edges with pix_en=1; holds otherwise. Latency is 2 pix_en ticks from x/y/video_on to RGB.
  - Stage 1 registers hit, hit_idx and video_on.
  - hit = 1 for block i iff ORIGIN_X + col*PITCH_X <= x < that + BLOCK_SIZE, and the same holds for y using row, ORIGIN_Y and PITCH_Y. Use half-open ranges.
  - Lowest index wins on overlap.
  - Stage 2 selects the colour:
    - video_on=0 -> 12'h000 (black during blanking).
    - hit and state=LIT and hit_idx==lit_idx -> LIT_COLOR.
    - hit otherwise -> IDLE_COLOR.
    - else -> BG_COLOR.
- Frame tick: pix_en && x==H_ACTIVE-1 && y==V_ACTIVE-1 (last visible pixel).
- Flash FSM (IDLE, LIT, DONE):
  - IDLE: flash_req=1 and flash_idx<NUM_BLOCKS -> latch lit_idx, counter=FLASH_FRAMES, go to LIT. flash_busy goes high the next clk.
  - IDLE: flash_idx >= NUM_BLOCKS -> request silently dropped; stay in IDLE; no done pulse.
  - LIT: flash_busy=1. Each frame tick decrements the counter. A frame tick with counter==1 -> DONE.
  - LIT: flash_req is ignored (not queued).
  - DONE: flash_done=1 for exactly one clk; flash_busy=0; next state IDLE.
  - DONE: a flash_req arriving in DONE is ignored. A new request is accepted only from IDLE, so the earliest re-acceptance is the clk after DONE.
- Frame tick in the same clk as acceptance does not decrement the new count.
- Reset during LIT or DONE returns to IDLE immediately with no done pulse. The RGB pipeline is cleared.
- Colour change on flash start/end takes effect at stage 2 on the next pix_en. No frame alignment of the lit colour is required.
- Arithmetic: block bounds are computed as 11-bit constants at elaboration, so no runtime multiply is needed. x/y comparisons are unsigned.

Decomposition:
- Shared package vga_pkg:
  - 640x480 timing constants (H_ACTIVE, V_ACTIVE).
  - 12-bit colour constants (BLACK, BLUE, GREEN, WHITE).
  - Typedef/localparam encoding for the FSM states.
- Sub-module block_hit_detect:
  - Combinational x/y -> hit/hit_idx from a generate loop over NUM_BLOCKS.
  - Reused later by an input-cursor overlay.
- The FSM and pipeline stay in vga_block_panel.

Test Plan:
1. Reset held 3 clks with pix_en toggling -> rgb=000, busy=0, done=0 throughout. After release with video_on=0 -> rgb stays 000.
2. Sweep x=266,329,330 at y=169 with defaults -> after 2 pix_en ticks, rgb = 0F0, 0F0, 00F. At x=410,y=313 -> 0F0 (block 3).
3. flash_req=1, flash_idx=2, FLASH_FRAMES=2 -> busy rises the next clk; block 2 renders FFF while blocks 0/1/3 render 0F0. After the 2nd frame tick, done pulses exactly 1 clk, busy falls, and block 2 returns to 0F0.
4. Second flash_req (idx=1) while busy -> ignored; lit_idx stays 2; exactly one done pulse. Request in the clk after done -> accepted.
5. flash_idx=5 with NUM_BLOCKS=4 -> no busy, no done, all blocks 0F0.
6. Reset asserted mid-LIT (after 1 of 30 frames) -> next clk busy=0, no done pulse, rgb=000. A new request after reset is accepted normally.
